mac_acc18: RTL and testbench
============================

Name: mac_acc18

Overview:
- Signed int8 multiply-accumulate stage sitting directly upstream of the int18-to-bf16 normalizer.
- Consumes a stream of operand pairs, multiplies each pair, and accumulates the products into an 18-bit signed saturating accumulator.
- On the beat marked last, it hands the finished dot product to the normalizer over a valid/ready handshake.
- Operands are Q4.4, so products and the accumulator are Q.8, matching the normalizer's FRAC_BITS = 8.

Parameters:
- IN_W, 8, operand width (signed, two's complement).
- ACC_W, 18, accumulator/result width (signed); must equal the normalizer input width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous discard of the partial accumulation.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept an operand pair.
- in_a  input  IN_W  signed operand A.
- in_b  input  IN_W  signed operand B.
- in_last  input  1  this pair is the final term of the vector.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed dot-product result (feeds the normalizer acc input).
- out_sat  output  1  saturation occurred anywhere in this result's vector.

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, sticky_sat=0, out_valid=0, out_acc=0, out_sat=0. Any partial vector is lost.
- Ready: in_ready = !out_valid || out_ready (combinational). Beat accepted when in_valid && in_ready.
- Arithmetic: prod = in_a*in_b as 2*IN_W-bit signed. sum = sext(acc) + sext(prod) in ACC_W+1 bits. Clamp sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-131072, 131071].
  - sat_now = 1 if clamping occurred.
  - Saturation applies per step; the next term adds to the clamped value.
- Accepted beat, in_last=0:
  - acc <= clamp(sum).
  - sticky_sat <= sticky_sat | sat_now.
- Accepted beat, in_last=1:
  - out_acc <= clamp(sum).
  - out_sat <= sticky_sat | sat_now.
  - out_valid <= 1.
  - acc <= 0, sticky_sat <= 0.
  - Next vector's first beat may be accepted the following cycle.
- Latency: result registered; out_valid rises the cycle after the last beat is accepted. A 1-beat vector yields out_acc = a*b.
- Output hold: while out_valid && !out_ready, out_acc and out_sat stay stable and in_ready=0.
- Output handoff:
  - out_valid && out_ready with no last beat accepted the same cycle: out_valid <= 0 next cycle.
  - Same cycle as a new last beat: out_valid stays 1 and out_acc/out_sat load the new result, so there is no bubble.
- clr:
  - Sets acc <= 0 and sticky_sat <= 0 and overrides any beat accepted that cycle; that beat, including a last beat, is dropped and produces no result.
  - Does not affect a pending out_valid/out_acc/out_sat.
  - in_ready is not gated by clr.
- Vector length is unbounded; no internal term counter. Saturation protects against overflow.
- No X propagation: out_acc holds its last value when out_valid=0.

Test Plan:
- Reset then 3 beats a=0x10, b=0x10 (1.0*1.0), last on beat 3, out_ready=1 -> out_valid pulses 1 cycle after beat 3, out_acc=768 (0x00300), out_sat=0.
- 9 beats a=127, b=127 (each product 16129), last on beat 9 -> out_acc=131071, out_sat=1. Following 1-beat vector a=2, b=3 -> out_acc=6, out_sat=0 (sticky cleared).
- 9 beats a=-128, b=127 (each -16256) -> out_acc=-131072, out_sat=1. Then vector {a=-128,b=127}x9 followed by {a=127,b=127} as a 10th last beat -> out_acc=-131072+16129=-114943, out_sat=1.
- Backpressure:
  - Result 6 pending with out_ready=0 for 5 cycles -> in_ready=0, out_acc held at 6.
  - Raise out_ready while a last beat a=1, b=1 is presented -> same-cycle handoff, next cycle out_valid=1 and out_acc=1.
- clr: beats a=4, b=4 twice, then clr asserted with a last beat a=4, b=4 -> no result. Next 1-beat vector a=1, b=5 -> out_acc=5.
- Assert rst_n low mid-vector (after 2 of 4 beats) and during a pending result -> all outputs 0 immediately. After release, a fresh 1-beat vector a=-3, b=7 -> out_acc=-21.

Source files
------------

// File: rtl/mac_acc18.sv
// Signed Q4.4 multiply-accumulate into an 18-bit saturating Q.8 accumulator.
// A finished dot product is handed downstream over a registered valid/ready port.
module mac_acc18 #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int PW = 2 * IN_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_sat_q, out_sat_d;

  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_clamped;
  logic             sat_now;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // One guard bit above ACC_W makes overflow visible as a mismatch of the top two bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sat_now     = 1'b0;
    a_ext       = {{IN_W{in_a[IN_W-1]}}, in_a};
    b_ext       = {{IN_W{in_b[IN_W-1]}}, in_b};
    prod        = a_ext * b_ext;
    sum         = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
    sum_clamped = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat_now     = 1'b1;
      sum_clamped = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clr) begin
      // A beat accepted together with clr is discarded, last or not.
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_acc_d   = sum_clamped;
        out_sat_d   = sticky_q | sat_now;
        out_valid_d = 1'b1;
        acc_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = sum_clamped;
        sticky_d = sticky_q | sat_now;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_acc18.sv
// Bench for mac_acc18: directed test-plan steps followed by random traffic,
// all checked against an integer-arithmetic dot-product model.
module tb_mac_acc18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] out_acc;
  logic        out_sat;

  int errors = 0;
  int checks = 0;

  // Reference model: running dot product in plain integers plus the expected output port state.
  int m_acc    = 0;
  bit m_sticky = 0;
  bit e_valid  = 0;
  int e_acc    = 0;
  bit e_sat    = 0;

  always #5 clk = ~clk;

  mac_acc18 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_sat   (out_sat)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, out_valid, e_valid);
    check({tag, ".out_acc"}, $signed(out_acc), e_acc);
    check({tag, ".out_sat"}, out_sat, e_sat);
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit v, input int a, input int b, input bit last,
                       input bit c, input bit ordy);
    bit exp_ready;
    bit accepted;
    int s;
    bit sat;
    in_valid  = v;
    in_a      = 8'(a);
    in_b      = 8'(b);
    in_last   = last;
    clr       = c;
    out_ready = ordy;
    exp_ready = !e_valid || ordy;
    #1;
    check("in_ready", in_ready, exp_ready);
    accepted = v && exp_ready;
    s   = m_acc + a * b;
    sat = 0;
    if (s > 131071) begin
      s = 131071; sat = 1;
    end else if (s < -131072) begin
      s = -131072; sat = 1;
    end
    if (e_valid && ordy) e_valid = 0;
    if (c) begin
      m_acc = 0; m_sticky = 0;
    end else if (accepted && last) begin
      e_acc = s; e_sat = m_sticky | sat; e_valid = 1;
      m_acc = 0; m_sticky = 0;
    end else if (accepted) begin
      m_acc = s; m_sticky = m_sticky | sat;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
    check_outputs("cycle");
  endtask

  task automatic repeat_beats(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) cycle(1, a, b, 0, 0, 1);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases after the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_acc = 0; m_sticky = 0; e_valid = 0; e_acc = 0; e_sat = 0;
    #1;
    check_outputs("reset");
    check("reset.in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1.0*1.0 three times
    repeat_beats(2, 8'h10, 8'h10);
    cycle(1, 8'h10, 8'h10, 1, 0, 1);
    check("tp_dot3", $signed(out_acc), 768);
    cycle(0, 0, 0, 0, 0, 1);
    check("tp_pulse_drop", out_valid, 0);

    // positive saturation, then sticky cleared on a fresh vector
    repeat_beats(8, 127, 127);
    cycle(1, 127, 127, 1, 0, 1);
    check("tp_pos_sat_acc", $signed(out_acc), 131071);
    check("tp_pos_sat_flag", out_sat, 1);
    cycle(1, 2, 3, 1, 0, 1);
    check("tp_after_sat", $signed(out_acc), 6);
    check("tp_after_sat_flag", out_sat, 0);

    // negative saturation, then recovery from the clamped value
    repeat_beats(8, -128, 127);
    cycle(1, -128, 127, 1, 0, 1);
    check("tp_neg_sat_acc", $signed(out_acc), -131072);
    repeat_beats(9, -128, 127);
    cycle(1, 127, 127, 1, 0, 1);
    check("tp_neg_recover", $signed(out_acc), -114943);
    check("tp_neg_recover_flag", out_sat, 1);

    // backpressure: result held for 5 cycles while a beat is offered and ignored
    cycle(1, 2, 3, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 9, 9, 1, 0, 0);
      check("tp_hold_acc", $signed(out_acc), 6);
    end
    cycle(1, 1, 1, 1, 0, 1);
    check("tp_handoff_acc", $signed(out_acc), 1);
    check("tp_handoff_valid", out_valid, 1);

    // clr drops the partial sum and the last beat presented with it
    repeat_beats(2, 4, 4);
    cycle(1, 4, 4, 1, 1, 1);
    check("tp_clr_no_result", out_valid, 0);
    cycle(1, 1, 5, 1, 0, 1);
    check("tp_after_clr", $signed(out_acc), 5);

    // reset mid-vector and while a result is pending
    repeat_beats(2, 10, 10);
    do_reset();
    cycle(1, 2, 2, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(1, -3, 7, 1, 0, 1);
    check("tp_after_reset", $signed(out_acc), -21);

    // random traffic with gaps, stalls, occasional clr and extreme operands
    for (int i = 0; i < 600; i++) begin
      int a;
      int b;
      if ($urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 1) != 0) ? 127 : -128;
        b = ($urandom_range(0, 1) != 0) ? 127 : -128;
      end else begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
      end
      cycle($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 7) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
